// File: rtl/fp_mult_result_collector.sv
// fp_mult_result_collector
// Collects the results of a fixed-latency FP multiplier into a small FIFO.
// A valid shift register tracks in-flight operations, and each capture is pushed in issue order.
// issue_ready grants an issue only when the FIFO is guaranteed to have room for it.
// Optional: define FP_COLLECT_STATS_EN to add the exc_count output.
// exc_count counts popped results that are inf or nan.
module fp_mult_result_collector #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] z,
  input  logic [7:0]  status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [7:0]  out_status,
  output logic        overflow
`ifdef FP_COLLECT_STATS_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = $clog2(LATENCY + 1);
  localparam int unsigned SW = ((CW > FW) ? CW : FW) + 1;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  status;
  } entry_t;

  logic [LATENCY-1:0] vld_sr;
  logic [FW-1:0]      in_flight;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [CW-1:0]      count;
  entry_t             mem [DEPTH];
  entry_t             head;
  logic               capture;
  logic               pop;
  logic               push;
  logic               full;

  // Issue tracking: one stage per cycle of multiplier latency
  if (LATENCY == 1) begin : g_sr1
    always_ff @(posedge clk) begin
      if (!rst) vld_sr <= '0;
      else      vld_sr <= issue_valid;
    end
  end else begin : g_srn
    always_ff @(posedge clk) begin
      if (!rst) vld_sr <= '0;
      else      vld_sr <= {vld_sr[LATENCY-2:0], issue_valid};
    end
  end

  // Population count of the in-flight operations
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      in_flight = in_flight + FW'(vld_sr[i]);
    end
  end

  assign capture     = vld_sr[LATENCY-1];
  assign full        = (count == CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle
  assign push        = capture & (~full | pop);
  assign head        = mem[rptr];
  assign out_z       = head.z;
  assign out_status  = head.status;
  assign issue_ready = (SW'(count) + SW'(in_flight)) < SW'(DEPTH);

  // FIFO storage, which is cleared on reset so that the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= '{z: z, status: status};
    end
  end

  // Pointers and occupancy; both pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop indicator for a capture that arrives into a full FIFO with no pop
  always_ff @(posedge clk) begin
    if (!rst)                       overflow <= 1'b0;
    else if (capture & full & ~pop) overflow <= 1'b1;
  end

`ifdef FP_COLLECT_STATS_EN
  // Saturating count of popped results flagged inf or nan
  always_ff @(posedge clk) begin
    if (!rst) begin
      exc_count <= '0;
    end else if (pop && (head.status[1] || head.status[2]) && (exc_count != 16'hFFFF)) begin
      exc_count <= exc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mult_result_collector.sv
// Bench for fp_mult_result_collector.
// It uses a table of directed cycles, hand-written corner sequences and random traffic.
// All three are checked against a queue-based model of issue times and FIFO contents.
module tb_fp_mult_result_collector;

  localparam int unsigned LATENCY = 3;
  localparam int unsigned DEPTH   = 4;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] z;
  logic [7:0]  status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        overflow;
`ifdef FP_COLLECT_STATS_EN
  logic [15:0] exc_count;
`endif

  fp_mult_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .z(z),
    .status(status),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z(out_z),
    .out_status(out_status),
    .overflow(overflow)
`ifdef FP_COLLECT_STATS_EN
    ,
    .exc_count(exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  st;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] z;
    logic [7:0]  st;
    logic        e_valid;
    logic        e_ready;
    logic        e_ovf;
    logic [31:0] e_z;
    logic [7:0]  e_st;
  } vec_t;

  int   checks;
  int   errors;
  int   cyc;
  bit   model_en;
  bit   m_ovf;
  int   m_exc;
  int   issues[$];
  ent_t q[$];
  vec_t tbl[7];

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive the inputs, compare at the falling edge, advance the model, then take the rising edge.
  task automatic run_cycle(input logic iv, input logic ordy, input logic rstv,
                           input logic [31:0] zv, input logic [7:0] stv, input int row);
    bit   cap;
    bit   pp;
    ent_t e;
    rst = rstv;
    issue_valid = iv;
    out_ready = ordy;
    z = zv;
    status = stv;
    @(negedge clk);
    if (row >= 0) begin
      check("tbl_out_valid", 40'(out_valid), 40'(tbl[row].e_valid));
      check("tbl_issue_ready", 40'(issue_ready), 40'(tbl[row].e_ready));
      check("tbl_overflow", 40'(overflow), 40'(tbl[row].e_ovf));
      check("tbl_out_z", 40'(out_z), 40'(tbl[row].e_z));
      check("tbl_out_status", 40'(out_status), 40'(tbl[row].e_st));
    end
    if (model_en) begin
      check("mdl_out_valid", 40'(out_valid), 40'(q.size() != 0));
      check("mdl_issue_ready", 40'(issue_ready), 40'((q.size() + issues.size()) < int'(DEPTH)));
      check("mdl_overflow", 40'(overflow), 40'(m_ovf));
      if (q.size() != 0) begin
        check("mdl_out_z", 40'(out_z), 40'(q[0].z));
        check("mdl_out_status", 40'(out_status), 40'(q[0].st));
      end
`ifdef FP_COLLECT_STATS_EN
      check("mdl_exc_count", 40'(exc_count), 40'(m_exc));
`endif
    end
    if (!rstv) begin
      q.delete();
      issues.delete();
      m_ovf = 1'b0;
      m_exc = 0;
    end else begin
      cap = (issues.size() != 0) && (issues[0] == cyc - int'(LATENCY));
      pp  = (q.size() != 0) && ordy;
      if (pp) begin
        e = q.pop_front();
        if ((e.st[1] || e.st[2]) && m_exc < 65535) m_exc++;
      end
      if (cap) begin
        void'(issues.pop_front());
        if (q.size() < int'(DEPTH)) q.push_back('{z: zv, st: stv});
        else m_ovf = 1'b1;
      end
      if (iv) issues.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) run_cycle(1'b0, ordy, 1'b1, $urandom, 8'($urandom), -1);
  endtask

  task automatic do_reset();
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, -1);
  endtask

  // Issue whenever issue_ready with the output stalled; return the number of issues made
  task automatic fill(output int accepted);
    logic iv;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      iv = issue_ready;
      if (iv) accepted++;
      run_cycle(iv, 1'b0, 1'b1, $urandom, 8'($urandom & 32'h3F), -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    checks = 0;
    errors = 0;
    cyc = 0;
    model_en = 1'b0;
    m_ovf = 1'b0;
    m_exc = 0;

    // One result through an idle block, with a stall for one cycle before it is popped
    tbl[0] = '{1'b1, 1'b0, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00};
    tbl[1] = '{1'b0, 1'b0, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00};
    tbl[3] = '{1'b0, 1'b0, 32'h40800000, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        8'h00, 1'b1, 1'b1, 1'b0, 32'h40800000, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 32'h0,        8'h00, 1'b1, 1'b1, 1'b0, 32'h40800000, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00};

    rst = 1'b0;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    z = '0;
    status = '0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    model_en = 1'b1;

    for (int r = 0; r < 7; r++) run_cycle(tbl[r].iv, tbl[r].ordy, 1'b1, tbl[r].z, tbl[r].st, r);

    // Backpressure fill: exactly DEPTH issues are granted
    fill(acc);
    check("fill_accepted", 40'(acc), 40'(DEPTH));
    check("fill_issue_ready", 40'(issue_ready), 40'(0));
    check("fill_out_valid", 40'(out_valid), 40'(1));
    check("fill_overflow", 40'(overflow), 40'(0));

    // Forced overflow: an extra issue into a full FIFO is dropped, and the sticky flag stays set
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'h04, -1);
    check("ovf_set", 40'(overflow), 40'(1));
    check("ovf_still_full", 40'(issue_ready), 40'(0));
    idle(4, 1'b1);
    check("ovf_drained", 40'(out_valid), 40'(0));
    check("ovf_sticky", 40'(overflow), 40'(1));
    do_reset();
    check("rst_overflow", 40'(overflow), 40'(0));
    check("rst_issue_ready", 40'(issue_ready), 40'(1));
    check("rst_out_z", 40'(out_z), 40'(0));

    // Push and pop in the same cycle on a full FIFO: the new result lands at the tail
    fill(acc);
    check("fill2_accepted", 40'(acc), 40'(DEPTH));
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 8'h11, -1);
    check("pp_overflow", 40'(overflow), 40'(0));
    check("pp_out_valid", 40'(out_valid), 40'(1));
    check("pp_issue_ready", 40'(issue_ready), 40'(0));
    idle(3, 1'b1);
    check("pp_tail_z", 40'(out_z), 40'(32'hCAFEF00D));
    check("pp_tail_status", 40'(out_status), 40'(8'h11));
    idle(1, 1'b1);
    check("pp_empty", 40'(out_valid), 40'(0));

    // Reset while two results are in flight: neither is ever captured
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, -1);
    do_reset();
    for (int i = 0; i < int'(LATENCY) + 3; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 32'h3F800000, 8'h00, -1);
      check("midrst_out_valid", 40'(out_valid), 40'(0));
    end
    check("midrst_issue_ready", 40'(issue_ready), 40'(1));

`ifdef FP_COLLECT_STATS_EN
    // Only the nan (8'h04) and inf (8'h02) results are counted; inexact (8'h20) is not
    for (int k = 0; k < 10; k++) begin
      run_cycle(k < 3, k >= 4, 1'b1, 32'h7F800000,
                (k == 3) ? 8'h04 : (k == 4) ? 8'h02 : (k == 5) ? 8'h20 : 8'h00, -1);
    end
    check("stats_exc_count", 40'(exc_count), 40'(2));
    do_reset();
    check("stats_rst", 40'(exc_count), 40'(0));
`endif

    // Random traffic: light draining first, to reach full and overflow, then heavier draining
    for (int i = 0; i < 1500; i++) begin
      run_cycle(1'($urandom_range(1)),
                (i < 750) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8),
                ($urandom_range(149) != 0), $urandom, 8'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
